// File: rtl/irq_pend_ctrl.sv
// Interrupt front end: synchronises 8 request lines, latches them as pending, feeds an external
// 8-to-3 priority encoder and presents its code to the CPU as irq/vec with ack and timeout.
// Define IRQ_LEVEL_MODE_EN to make pending follow the synchronised request level instead.
module irq_pend_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] mask,
  output logic [7:0] enc_d,
  output logic       enc_dis,
  input  logic [2:0] enc_code,
  output logic       irq,
  output logic [2:0] vec,
  input  logic       ack,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    GAP    = 2'd2
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

  logic [SYNC_STAGES-1:0][7:0] sync_q, sync_d;
  logic [7:0]                  req_lvl;
  logic [7:0]                  pend;

  state_e     state_q, state_d;
  logic       irq_q, irq_d;
  logic [2:0] vec_q, vec_d;
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;

  // Stage 0 captures the raw asynchronous line; the last stage is the usable level.
  assign sync_d  = {sync_q[SYNC_STAGES-2:0], req};
  assign req_lvl = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every flop here is state, so all use non-blocking assignment and all are reset,
      // including the synchroniser stages, so a reset never manufactures a spurious edge.
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

`ifndef IRQ_LEVEL_MODE_EN
  logic [7:0] lvl_prev_q;
  logic [7:0] req_edge;
  logic [7:0] pend_q, pend_d;
  logic [7:0] pend_clr;

  assign req_edge = req_lvl & ~lvl_prev_q;

  // Only an acknowledged vector clears its bit; a fresh edge in the same cycle wins.
  always_comb begin
    pend_clr = '0;
    if (state_q == ASSERT && ack) begin
      pend_clr = 8'd1 << vec_q;
    end
    pend_d = (pend_q & ~pend_clr) | req_edge;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_prev_q <= '0;
      pend_q     <= '0;
    end else begin
      lvl_prev_q <= req_lvl;
      pend_q     <= pend_d;
    end
  end

  assign pend = pend_q;
`else
  assign pend = req_lvl;
`endif

  assign enc_d   = pend & ~mask;
  assign enc_dis = (enc_d == 8'd0) || (state_q != IDLE);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned
    // and no latch is inferred.
    state_d   = state_q;
    irq_d     = irq_q;
    vec_d     = vec_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enc_d != 8'd0) begin
          vec_d   = enc_code;
          irq_d   = 1'b1;
          cnt_d   = '0;
          state_d = ASSERT;
        end
      end
      ASSERT: begin
        // An ack in the expiry cycle takes precedence over the timeout.
        if (ack) begin
          irq_d   = 1'b0;
          state_d = GAP;
        end else if (cnt_q == CNT_LAST) begin
          irq_d     = 1'b0;
          timeout_d = 1'b1;
          state_d   = GAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        irq_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      irq_q     <= 1'b0;
      vec_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      irq_q     <= irq_d;
      vec_q     <= vec_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign irq     = irq_q;
  assign vec     = vec_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_irq_pend_ctrl.sv
// Bench for irq_pend_ctrl: a cycle-level behavioural model checked every cycle, plus
// directed scenarios with hand-computed expectations. Follows IRQ_LEVEL_MODE_EN if defined.
module tb_irq_pend_ctrl;

  localparam int S = 2;
  localparam int T = 15;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req   = 8'h00;
  logic [7:0] mask  = 8'h00;
  logic       ack   = 1'b0;
  logic [7:0] enc_d;
  logic       enc_dis;
  logic [2:0] enc_code;
  logic       irq;
  logic [2:0] vec;
  logic       timeout;

  int n_cmp  = 0;
  int n_bad  = 0;
  int to_cnt = 0;

  irq_pend_ctrl #(.SYNC_STAGES(S), .ACK_TIMEOUT(T)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .mask     (mask),
    .enc_d    (enc_d),
    .enc_dis  (enc_dis),
    .enc_code (enc_code),
    .irq      (irq),
    .vec      (vec),
    .ack      (ack),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  // External 8-to-3 priority encoder: highest set bit wins, disable forces 0.
  always_comb begin
    enc_code = 3'd0;
    if (!enc_dis) begin
      for (int i = 0; i < 8; i++) begin
        if (enc_d[i]) enc_code = 3'(i);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_hist[$];   // req sampled at each clock edge, newest first
  logic [7:0] m_pend;
  logic       m_irq;
  logic       m_gap;
  logic [2:0] m_vec;
  logic       m_to;
  int         m_age;

  function automatic logic [2:0] top_bit(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) return 3'(i);
    end
    return 3'd0;
  endfunction

  function automatic logic [7:0] model_enc_d();
`ifdef IRQ_LEVEL_MODE_EN
    return m_hist[S-1] & ~mask;
`else
    return m_pend & ~mask;
`endif
  endfunction

  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i <= S; i++) m_hist.push_back(8'h00);
    m_pend = 8'h00;
    m_irq  = 1'b0;
    m_gap  = 1'b0;
    m_vec  = 3'd0;
    m_to   = 1'b0;
    m_age  = 0;
  endtask

  task automatic model_step();
    logic [7:0] cur_d;
    logic [7:0] edges;
    logic [7:0] clr;
    logic       to_next;
    cur_d   = model_enc_d();
    edges   = m_hist[S-1] & ~m_hist[S];
    clr     = 8'h00;
    to_next = 1'b0;
    if (m_irq) begin
      if (ack) begin
        clr[m_vec] = 1'b1;
        m_irq = 1'b0;
        m_gap = 1'b1;
      end else if (m_age == T - 1) begin
        m_irq   = 1'b0;
        m_gap   = 1'b1;
        to_next = 1'b1;
      end else begin
        m_age++;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (cur_d != 8'h00) begin
      m_vec = top_bit(cur_d);
      m_irq = 1'b1;
      m_age = 0;
    end
    m_to   = to_next;
    m_pend = (m_pend & ~clr) | edges;
    m_hist.push_front(req);
    void'(m_hist.pop_back());
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      logic [7:0] exp_d;
      @(negedge clk);
      exp_d = model_enc_d();
      if (timeout === 1'b1) to_cnt++;
      check("cyc_enc_d", enc_d, exp_d);
      check("cyc_enc_dis", enc_dis, (exp_d == 8'h00) || m_irq || m_gap);
      check("cyc_irq", irq, m_irq);
      check("cyc_timeout", timeout, m_to);
      if (m_irq) check("cyc_vec", vec, m_vec);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_irq(input string name, input int budget);
    int i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (irq !== 1'b1 && i < budget);
    check({name, "_irq_seen"}, irq, 1);
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
  endtask

  initial begin
    int hi;
    // Reset values while rst_n is low.
    #1;
    check("rst_irq", irq, 0);
    check("rst_vec", vec, 0);
    check("rst_timeout", timeout, 0);
    check("rst_enc_d", enc_d, 8'h00);
    check("rst_enc_dis", enc_dis, 1);
    cyc(2);
    rst_n = 1'b1;

    // Idle for 20 cycles.
    cyc(20);
    @(negedge clk);
    check("idle_irq", irq, 0);
    check("idle_enc_dis", enc_dis, 1);
    check("idle_enc_d", enc_d, 8'h00);
    check("idle_no_timeout", to_cnt, 0);

`ifndef IRQ_LEVEL_MODE_EN
    // Two simultaneous edges, served highest first.
    cyc(1);
    req = 8'h24;
    cyc(3);
    @(negedge clk);
    check("t2_irq_n2", irq, 0);
    check("t2_pend", enc_d, 8'h24);
    cyc(1);
    @(negedge clk);
    check("t2_irq_n3", irq, 1);
    check("t2_vec5", vec, 5);
    cyc(1);
    pulse_ack();
    @(negedge clk);
    check("t2_gap_irq", irq, 0);
    check("t2_pend_after_ack", enc_d, 8'h04);
    check("t2_gap_dis", enc_dis, 1);
    cyc(1);
    @(negedge clk);
    check("t2_idle_irq", irq, 0);
    check("t2_idle_dis", enc_dis, 0);
    cyc(1);
    @(negedge clk);
    check("t2_irq2", irq, 1);
    check("t2_vec2", vec, 2);
    cyc(1);
    pulse_ack();
    cyc(2);
    @(negedge clk);
    check("t2_pend_empty", enc_d, 8'h00);
    check("t2_irq_done", irq, 0);
    cyc(1);
    req = 8'h00;

    // Masked pending bit, unmask, remask during ASSERT.
    mask = 8'h80;
    req  = 8'h80;
    cyc(6);
    @(negedge clk);
    check("t3_masked_irq", irq, 0);
    check("t3_masked_enc_d", enc_d, 8'h00);
    check("t3_masked_dis", enc_dis, 1);
    cyc(1);
    mask = 8'h00;
    @(negedge clk);
    check("t3_unmask_enc_d", enc_d, 8'h80);
    cyc(1);
    @(negedge clk);
    check("t3_irq", irq, 1);
    check("t3_vec7", vec, 7);
    cyc(1);
    mask = 8'h80;
    cyc(3);
    @(negedge clk);
    check("t3_remask_irq", irq, 1);
    check("t3_remask_vec", vec, 7);
    check("t3_remask_enc_d", enc_d, 8'h00);
    cyc(1);
    pulse_ack();
    mask = 8'h00;
    cyc(3);
    @(negedge clk);
    check("t3_cleared", enc_d, 8'h00);
    check("t3_irq_done", irq, 0);

    // Timeout: irq high exactly T cycles, pending kept, re-asserted after GAP.
    cyc(1);
    req = 8'h01;
    wait_irq("t4", 10);
    check("t4_vec0", vec, 0);
    hi = 0;
    while (irq === 1'b1 && hi < 40) begin
      hi++;
      @(negedge clk);
    end
    check("t4_high_cycles", hi, T);
    check("t4_timeout_pulse", timeout, 1);
    check("t4_pend_kept", enc_d, 8'h01);
    @(negedge clk);
    check("t4_pulse_one_cycle", timeout, 0);
    check("t4_idle_irq", irq, 0);
    @(negedge clk);
    check("t4_reassert", irq, 1);
    check("t4_reassert_vec", vec, 0);
    // Ack lands exactly in the expiry cycle.
    cyc(T - 1);
    pulse_ack();
    @(negedge clk);
    check("t4_ack_exp_irq", irq, 0);
    check("t4_ack_exp_no_to", timeout, 0);
    check("t4_ack_exp_clr", enc_d, 8'h00);
    check("t4_total_timeouts", to_cnt, 1);

    // New edge on bit 3 in the same cycle as ack of vec 3.
    cyc(1);
    req = 8'h08;
    wait_irq("t5", 10);
    check("t5_vec3", vec, 3);
    cyc(1);
    req = 8'h00;
    cyc(3);
    req = 8'h08;
    cyc(2);
    pulse_ack();
    @(negedge clk);
    check("t5_gap_irq", irq, 0);
    check("t5_pend_kept", enc_d, 8'h08);
    cyc(1);
    @(negedge clk);
    cyc(1);
    @(negedge clk);
    check("t5_reassert", irq, 1);
    check("t5_reassert_vec", vec, 3);
`else
    // Level mode: a held request re-asserts after every ack.
    cyc(1);
    req = 8'h10;
    wait_irq("lv", 10);
    check("lv_vec4", vec, 4);
    cyc(1);
    pulse_ack();
    @(negedge clk);
    check("lv_gap_irq", irq, 0);
    check("lv_still_pending", enc_d, 8'h10);
    cyc(1);
    @(negedge clk);
    cyc(1);
    @(negedge clk);
    check("lv_reassert", irq, 1);
    check("lv_reassert_vec", vec, 4);
    cyc(1);
    req = 8'h00;
    pulse_ack();
    cyc(6);
    @(negedge clk);
    check("lv_no_more_irq", irq, 0);
    check("lv_enc_d_empty", enc_d, 8'h00);
    cyc(1);
    req = 8'h08;
    wait_irq("lv2", 10);
`endif

    // Reset in the middle of ASSERT.
    cyc(2);
    rst_n = 1'b0;
    req   = 8'h00;
    #1;
    check("rst_mid_irq", irq, 0);
    check("rst_mid_vec", vec, 0);
    check("rst_mid_enc_d", enc_d, 8'h00);
    check("rst_mid_timeout", timeout, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(5);
    @(negedge clk);
    check("post_rst_pend_lost", enc_d, 8'h00);
    check("post_rst_irq", irq, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish by t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
